// File: rtl/par_to_ser_buffered.sv
// Buffered parallel-to-serial converter: valid/ready words enter a DEPTH-entry FIFO
// and leave one bit per SerClock edge, with selectable bit order and inter-word gap.
module par_to_ser_buffered #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic                       SerClock,
    input  logic                       ResetN,
    input  logic                       ParValid,
    output logic                       ParReady,
    input  logic [WIDTH-1:0]           BusIn,
    output logic                       SerOut,
    output logic                       SerValidFlag,
    output logic                       FrameStart,
    output logic                       Busy,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int IDX_W    = $clog2(WIDTH);
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0] idx_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             ser_out_q, ser_vld_q, frame_q;

    logic             push, pop, last_bit, gap_done;
    logic [WIDTH-1:0] head;

    assign ParReady = (count_q < CNT_W'(DEPTH));
    assign push     = ParValid && ParReady;
    assign head     = mem_q[rd_ptr_q];
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
    assign gap_done = (gap_cnt_q == GAP_W'(GAP_LAST));

    // A word may leave the FIFO when the line is idle, the gap has expired, or
    // (with no gap) the current word is finishing; there is no empty bypass.
    assign pop = (count_q != '0) &&
                 ((state_q == S_IDLE) ||
                  (state_q == S_GAP && gap_done) ||
                  (state_q == S_SHIFT && last_bit && GAP == 0));

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SerClock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // NOTE: storage has no reset; the reset pointers and count make stale contents unreachable.
    always_ff @(posedge SerClock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= BusIn;
        end
    end

    always_ff @(posedge SerClock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            ser_out_q <= 1'b0;
            ser_vld_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (pop) begin
                state_q   <= S_SHIFT;
                idx_q     <= '0;
                ser_vld_q <= 1'b1;
                frame_q   <= 1'b1;
                ser_out_q <= (LSB_FIRST != 0) ? head[0] : head[WIDTH-1];
                shreg_q   <= (LSB_FIRST != 0) ? (head >> 1) : (head << 1);
            end else begin
                case (state_q)
                    S_SHIFT: begin
                        if (last_bit) begin
                            ser_vld_q <= 1'b0;
                            ser_out_q <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= (GAP > 0) ? S_GAP : S_IDLE;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            ser_out_q <= (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
                            shreg_q   <= (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
                        end
                    end
                    S_GAP: begin
                        if (gap_done) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign SerOut       = ser_out_q;
    assign SerValidFlag = ser_vld_q;
    assign FrameStart   = frame_q;
    assign Busy         = (state_q != S_IDLE) || (count_q != '0);
    assign Count        = count_q;

endmodule

// File: tb/tb_par_to_ser_buffered.sv
// Bench for par_to_ser_buffered: two configurations, each shadowed every cycle by a
// word-level queue model, plus table-driven and hand-written corner-case sequences.
module tb_par_to_ser_buffered;

    localparam int W       = 16;
    localparam int A_DEPTH = 4;
    localparam int A_LSB   = 0;
    localparam int A_GAP   = 1;
    localparam int B_DEPTH = 3;
    localparam int B_LSB   = 1;
    localparam int B_GAP   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ready, a_ser, a_vld, a_frame, a_busy;
    logic        b_ready, b_ser, b_vld, b_frame, b_busy;
    logic [2:0]  a_count;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    par_to_ser_buffered #(.WIDTH(W), .DEPTH(A_DEPTH), .LSB_FIRST(A_LSB), .GAP(A_GAP)) u_dut_a (
        .SerClock(clk), .ResetN(rst_n), .ParValid(a_valid), .ParReady(a_ready), .BusIn(a_data),
        .SerOut(a_ser), .SerValidFlag(a_vld), .FrameStart(a_frame), .Busy(a_busy), .Count(a_count)
    );

    par_to_ser_buffered #(.WIDTH(W), .DEPTH(B_DEPTH), .LSB_FIRST(B_LSB), .GAP(B_GAP)) u_dut_b (
        .SerClock(clk), .ResetN(rst_n), .ParValid(b_valid), .ParReady(b_ready), .BusIn(b_data),
        .SerOut(b_ser), .SerValidFlag(b_vld), .FrameStart(b_frame), .Busy(b_busy), .Count(b_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a word leaves the FIFO whenever the line schedule is empty and expands into
    // WIDTH {valid,bit,frame} slots followed by GAP idle slots; one slot per edge.
    logic [15:0] fa[$], fb[$];
    logic [2:0]  sa[$], sb[$];
    logic [2:0]  ea = '0, eb = '0;
    logic        aa = 1'b0, ab = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model_a
        int pre;
        logic [15:0] w;
        if (!rst_n) begin
            fa.delete();
            sa.delete();
            ea <= '0;
            aa <= 1'b0;
        end else begin
            pre = fa.size();
            if (sa.size() == 0 && pre > 0) begin
                w = fa.pop_front();
                for (int i = 0; i < W; i++)
                    sa.push_back({1'b1, (A_LSB != 0) ? w[i] : w[W-1-i], i == 0});
                for (int g = 0; g < A_GAP; g++) sa.push_back(3'b000);
            end
            aa <= (sa.size() != 0);
            ea <= (sa.size() != 0) ? sa.pop_front() : 3'b000;
            if (a_valid && pre < A_DEPTH) fa.push_back(a_data);
        end
    end

    always @(posedge clk or negedge rst_n) begin : model_b
        int pre;
        logic [15:0] w;
        if (!rst_n) begin
            fb.delete();
            sb.delete();
            eb <= '0;
            ab <= 1'b0;
        end else begin
            pre = fb.size();
            if (sb.size() == 0 && pre > 0) begin
                w = fb.pop_front();
                for (int i = 0; i < W; i++)
                    sb.push_back({1'b1, (B_LSB != 0) ? w[i] : w[W-1-i], i == 0});
                for (int g = 0; g < B_GAP; g++) sb.push_back(3'b000);
            end
            ab <= (sb.size() != 0);
            eb <= (sb.size() != 0) ? sb.pop_front() : 3'b000;
            if (b_valid && pre < B_DEPTH) fb.push_back(b_data);
        end
    end

    always @(posedge clk) begin
        #1;
        check("m_a_vld",   a_vld,   ea[2]);
        check("m_a_ser",   a_ser,   ea[1]);
        check("m_a_frame", a_frame, ea[0]);
        check("m_a_count", a_count, fa.size());
        check("m_a_ready", a_ready, fa.size() < A_DEPTH);
        check("m_a_busy",  a_busy,  aa || fa.size() != 0);
        check("m_b_vld",   b_vld,   eb[2]);
        check("m_b_ser",   b_ser,   eb[1]);
        check("m_b_frame", b_frame, eb[0]);
        check("m_b_count", b_count, fb.size());
        check("m_b_ready", b_ready, fb.size() < B_DEPTH);
        check("m_b_busy",  b_busy,  ab || fb.size() != 0);
    end

    task automatic step(input logic av, input logic [15:0] ad, input logic bv, input logic [15:0] bd);
        @(negedge clk);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("rst_a_count", a_count, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_a_out",   {a_ser, a_vld, a_frame, a_busy}, 0);
        check("rst_b_out",   {b_ser, b_vld, b_frame, b_busy, b_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        ser, vld, frame, busy;
        logic [2:0]  cnt;
    } vec_t;

    vec_t        tbl [19];
    logic [15:0] pat;
    logic [15:0] got[$];
    logic [15:0] acc;
    int          nb;

    initial begin
        pat = 16'b1010010111000011;
        tbl[0] = '{1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{1'b0, 16'h5A3C, pat[16-i], 1'b1, i == 1, 1'b1, 3'd0};
        tbl[17] = '{1'b0, 16'h5A3C, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[18] = '{1'b0, 16'h5A3C, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

        repeat (3) @(posedge clk);
        do_reset();

        // MSB-first single word with one idle gap cycle
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0, 16'h0);
            check($sformatf("tbl%0d_ser", i),   a_ser,   tbl[i].ser);
            check($sformatf("tbl%0d_vld", i),   a_vld,   tbl[i].vld);
            check($sformatf("tbl%0d_frame", i), a_frame, tbl[i].frame);
            check($sformatf("tbl%0d_busy", i),  a_busy,  tbl[i].busy);
            check($sformatf("tbl%0d_count", i), a_count, tbl[i].cnt);
        end

        // ParValid held: FIFO fills, no full bypass when a pop coincides
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 16'h1000 + 16'(k), 1'b0, 16'h0);
            if (k == 5)  check("fill_count5", {a_ready, a_count}, {1'b0, 3'd4});
            if (k == 6)  check("fill_count6", {a_ready, a_count}, {1'b0, 3'd4});
            if (k == 19) check("fill_pop19",  {a_frame, a_ready, a_count}, {1'b1, 1'b1, 3'd3});
            if (k == 20) check("fill_push20", {a_ready, a_count}, {1'b0, 3'd4});
        end
        for (int k = 0; k < 90; k++) step(1'b0, 16'h0, 1'b0, 16'h0);
        check("fill_drained", a_busy, 0);

        // Reset during bit 7 of the first word with two words buffered
        do_reset();
        step(1'b1, 16'hC0DE, 1'b0, 16'h0);
        step(1'b1, 16'hBEEF, 1'b0, 16'h0);
        step(1'b1, 16'h1234, 1'b0, 16'h0);
        for (int k = 4; k <= 9; k++) step(1'b0, 16'h0, 1'b0, 16'h0);
        check("mid_pre_vld",   a_vld,   1);
        check("mid_pre_count", a_count, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",   {a_ser, a_vld, a_frame, a_busy}, 0);
        check("mid_rst_count", a_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            if (a_vld) nb++;
        end
        check("mid_no_resume", nb, 0);

        // Push and pop on the same edge with two words buffered
        do_reset();
        step(1'b1, 16'h1111, 1'b0, 16'h0);
        step(1'b1, 16'h2222, 1'b0, 16'h0);
        step(1'b1, 16'h3333, 1'b0, 16'h0);
        check("pp_count_pre", a_count, 2);
        for (int k = 4; k <= 18; k++) step(1'b0, 16'h0, 1'b0, 16'h0);
        got.delete();
        acc = '0;
        nb  = 0;
        for (int k = 0; k < 60; k++) begin
            step(k == 0, 16'h4444, 1'b0, 16'h0);
            if (k == 0) check("pp_same_edge", {a_frame, a_count}, {1'b1, 3'd2});
            if (a_vld) begin
                acc = {acc[14:0], a_ser};
                nb++;
                if (nb == 16) begin
                    got.push_back(acc);
                    nb = 0;
                end
            end
        end
        check("pp_nwords", got.size(), 3);
        if (got.size() == 3) begin
            check("pp_word0", got[0], 16'h2222);
            check("pp_word1", got[1], 16'h3333);
            check("pp_word2", got[2], 16'h4444);
        end

        // LSB-first, 16'h0001: a single 1 then fifteen 0s
        do_reset();
        step(1'b0, 16'h0, 1'b1, 16'h0001);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            check($sformatf("lsb_bit%0d", k), {b_vld, b_ser, b_frame}, (k == 0) ? 3'b111 : 3'b100);
        end
        step(1'b0, 16'h0, 1'b0, 16'h0);
        check("lsb_done", {b_vld, b_busy}, 0);

        // GAP=0: two back-to-back words give 32 contiguous valid bits
        do_reset();
        step(1'b0, 16'h0, 1'b1, 16'hFFFF);
        for (int t = 2; t <= 34; t++) begin
            step(1'b0, 16'h0, t == 2, 16'h0000);
            check($sformatf("b2b_vld%0d", t),   b_vld,   t <= 33);
            check($sformatf("b2b_frame%0d", t), b_frame, (t == 2) || (t == 18));
            if (t <= 33) check($sformatf("b2b_ser%0d", t), b_ser, t < 18);
        end

        // Random traffic with occasional resets, checked by the model every edge
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(299) != 0);
            a_valid = ($urandom_range(9) < 6);
            a_data  = 16'($urandom);
            b_valid = ($urandom_range(9) < 6);
            b_data  = 16'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 120; k++) step(1'b0, 16'($urandom), 1'b0, 16'($urandom));
        check("final_idle", {a_busy, b_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
